uart_tx_fifo: RTL and testbench

- Byte buffer directly upstream of the UART transmitter.
- Accepts bytes from the host side, stores them in a circular FIFO, and hands them one at a time to the transmitter using the transmitter's ready/tx_data/tdre handshake.
- Lets software burst-write a message without polling tdre per byte.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write port and transmitter handshake bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tdre;
    logic          ready;
    logic [7:0]    tx_data;

    modport master (
        output wr_en, wr_data, flush, tdre,
        input  full, empty, count, overflow, ready, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tdre,
        output full, empty, count, overflow, ready, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO feeding the UART transmitter via ready/tx_data/tdre
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           clr,
    uart_tx_fifo_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_q;
    logic [7:0]     tx_data_q;
    logic           overflow_q;
    logic           full_w;
    logic           empty_w;
    logic           pop;
    logic           push;

    assign full_w  = (count_q == FULL_COUNT);
    assign empty_w = (count_q == '0);

    // Flush wins over both pop and push; a pop frees a slot for a same-cycle write.
    assign pop  = (state == IDLE) && bus.tdre && !empty_w && !bus.flush;
    assign push = bus.wr_en && (!full_w || pop) && !bus.flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.wr_en && full_w && !pop && !bus.flush;
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    tx_data_q <= mem[rd_ptr];
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT_ACK only exits on tdre low, so IDLE always sees a fresh low->high tdre before reissuing.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (pop) state_nxt = LOAD;
                LOAD:     state_nxt = WAIT_ACK;
                WAIT_ACK: if (!bus.tdre) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    assign bus.ready    = (state == LOAD);
    assign bus.tx_data  = tx_data_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic clr;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(16)) bus ();

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_ready(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.ready) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Transmitter model: accept the byte, drop tdre, then raise it again a few cycles later.
    task automatic tx_accept(input string tag, input logic [7:0] exp);
        logic seen;
        wait_ready(seen);
        check({tag, "_ready"}, 32'(seen), 32'd1);
        if (seen) begin
            check(tag, 32'(bus.tx_data), 32'(exp));
            step();
            bus.tdre = 1'b0;
            step();
            step();
            bus.tdre = 1'b1;
        end
    endtask

    task automatic count_ready(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.ready) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pulses;

        clr         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;
        bus.tdre    = 1'b1;

        // 1: reset and idle
        step(); step(); step();
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_ready",    32'(bus.ready),    32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'h00);
        clr = 1'b1;
        count_ready(10, pulses);
        check("idle_no_ready", 32'(pulses),      32'd0);
        check("idle_empty",    32'(bus.empty),   32'd1);
        check("idle_count",    32'(bus.count),   32'd0);

        // 2: single byte latency and one ready per acceptance
        push_byte(8'hA5);
        check("t2_ready_c1", 32'(bus.ready),   32'd0);
        check("t2_count_c1", 32'(bus.count),   32'd1);
        step();
        check("t2_ready_c2", 32'(bus.ready),   32'd1);
        check("t2_tx_data",  32'(bus.tx_data), 32'hA5);
        step();
        check("t2_ready_pulse", 32'(bus.ready), 32'd0);
        bus.tdre = 1'b0;
        count_ready(10, pulses);
        bus.tdre = 1'b1;
        check("t2_no_ready_low", 32'(pulses), 32'd0);
        count_ready(10, pulses);
        check("t2_no_second_ready", 32'(pulses),    32'd0);
        check("t2_count",           32'(bus.count), 32'd0);
        check("t2_empty",           32'(bus.empty), 32'd1);

        // 3: fill, overflow, drain in order
        bus.tdre = 1'b0;
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        check("t3_full",  32'(bus.full),  32'd1);
        check("t3_count", 32'(bus.count), 32'd16);
        push_byte(8'h11);
        check("t3_overflow",   32'(bus.overflow), 32'd1);
        check("t3_count_ovf",  32'(bus.count),    32'd16);
        step();
        check("t3_overflow_pulse", 32'(bus.overflow), 32'd0);
        bus.tdre = 1'b1;
        for (int i = 1; i <= 16; i++) tx_accept($sformatf("t3_byte%0d", i), 8'(i));
        count_ready(20, pulses);
        check("t3_no_extra", 32'(pulses),    32'd0);
        check("t3_empty",    32'(bus.empty), 32'd1);

        // 4: write while full and popping, pointer wrap
        bus.tdre = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        check("t4_full", 32'(bus.full), 32'd1);
        bus.tdre    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h30;
        step();
        bus.wr_en = 1'b0;
        check("t4_count",    32'(bus.count),    32'd16);
        check("t4_overflow", 32'(bus.overflow), 32'd0);
        check("t4_ready",    32'(bus.ready),    32'd1);
        for (int i = 0; i <= 16; i++) tx_accept($sformatf("t4_byte%0d", i), 8'h20 + 8'(i));
        check("t4_empty", 32'(bus.empty), 32'd1);

        // 5: flush with bytes queued behind one in flight
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h51;
        step();
        bus.wr_data = 8'h52;
        step();
        check("t5_ready",   32'(bus.ready),   32'd1);
        check("t5_tx_data", 32'(bus.tx_data), 32'h51);
        bus.wr_data = 8'h53;
        step();
        bus.wr_en = 1'b0;
        check("t5_count_pre", 32'(bus.count), 32'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t5_count",  32'(bus.count), 32'd0);
        check("t5_empty",  32'(bus.empty), 32'd1);
        check("t5_ready0", 32'(bus.ready), 32'd0);
        bus.tdre = 1'b0;
        step(); step(); step();
        bus.tdre = 1'b1;
        count_ready(20, pulses);
        check("t5_no_issue", 32'(pulses),      32'd0);
        check("t5_tx_held",  32'(bus.tx_data), 32'h51);

        // 6: async reset while ready is high
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        step();
        bus.wr_data = 8'h78;
        step();
        bus.wr_en = 1'b0;
        check("t6_ready_pre", 32'(bus.ready), 32'd1);
        check("t6_count_pre", 32'(bus.count), 32'd1);
        clr = 1'b0;
        #1;
        check("t6_ready_async", 32'(bus.ready),   32'd0);
        check("t6_count",       32'(bus.count),   32'd0);
        check("t6_empty",       32'(bus.empty),   32'd1);
        check("t6_tx_data",     32'(bus.tx_data), 32'h00);
        step();
        clr = 1'b1;
        push_byte(8'h3C);
        check("t6_ready_c1", 32'(bus.ready), 32'd0);
        step();
        check("t6_ready_c2", 32'(bus.ready),   32'd1);
        check("t6_tx_3c",    32'(bus.tx_data), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
